// File: rtl/grf_operand_arb.sv
// ---------------------------------------------------------------------------
// grf_operand_arb
// Arbitrates operand fetches from the ALU-issue (req0) and LSU-issue (req1)
// requesters onto two GRF read ports and two bypass-buffer read ports. The
// arbiter grants both requests together when the read ports suffice, and
// otherwise picks one winner using starvation priority and then a
// round-robin pointer. Read data returns one cycle after the grant and is
// collected into a 2-entry response FIFO per requester. A per-requester
// credit counter covers FIFO entries plus reads in flight, so a FIFO can
// never overflow.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   reqN_valid / reqN_ready     operand-fetch handshake (ready is combinational)
//   reqN_rs1/rs2                GRF source indices
//   reqN_dep1/dep2              bypass tag, 4'hF = read GRF instead
//   reqN_use1/use2              operand is required
//   grf_renP/raddrP/rdataP      two synchronous GRF read ports
//   bp_renP/raddrP/rdataP       two synchronous bypass read ports
//   bp_vmask                    bypass entry k holds a produced value
//   rspN_valid/ready/opl/opr    operand response handshake and data
// ---------------------------------------------------------------------------
module grf_operand_arb #(
   parameter int STARVE_LIMIT = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [4:0]  req0_rs1,
   input  logic [4:0]  req0_rs2,
   input  logic [3:0]  req0_dep1,
   input  logic [3:0]  req0_dep2,
   input  logic        req0_use1,
   input  logic        req0_use2,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [4:0]  req1_rs1,
   input  logic [4:0]  req1_rs2,
   input  logic [3:0]  req1_dep1,
   input  logic [3:0]  req1_dep2,
   input  logic        req1_use1,
   input  logic        req1_use2,
   output logic        grf_ren0,
   output logic [4:0]  grf_raddr0,
   input  logic [31:0] grf_rdata0,
   output logic        grf_ren1,
   output logic [4:0]  grf_raddr1,
   input  logic [31:0] grf_rdata1,
   output logic        bp_ren0,
   output logic [3:0]  bp_raddr0,
   input  logic [31:0] bp_rdata0,
   output logic        bp_ren1,
   output logic [3:0]  bp_raddr1,
   input  logic [31:0] bp_rdata1,
   input  logic [14:0] bp_vmask,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_opl,
   output logic [31:0] rsp0_opr,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_opl,
   output logic [31:0] rsp1_opr
);

   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      SRC_ZERO = 2'd0,
      SRC_GRF  = 2'd1,
      SRC_BP   = 2'd2
   } srcT;

   // Operand slots are numbered 0..3 as req0.opl, req0.opr, req1.opl,
   // req1.opr; this order also sets read-port allocation priority.
   logic [3:0][4:0]   opRs;
   logic [3:0][3:0]   opDep;
   logic [3:0]        opUse;
   logic [1:0]        reqValid;
   logic [1:0]        rspReady;
   logic [15:0]       vmaskPad;

   logic [3:0]        needG, needB, bpOk;
   logic [1:0][2:0]   gCnt, bCnt;
   logic [1:0]        eligible, grant;
   logic              dualOk;
   srcT               opSrc_d [4];
   logic [3:0]        opPort_d;
   logic [3:0][31:0]  opData;
   logic [1:0][63:0]  pushData;
   logic [1:0][63:0]  head;
   logic [1:0]        rspValid, pop;

   logic [1:0][1:0]   credit_q;
   logic              rr_q;
   logic [1:0][SW-1:0] starve_q;
   logic [1:0]        pend_q;
   srcT               opSrc_q [4];
   logic [3:0]        opPort_q;
   logic [1:0][1:0][63:0] fifoMem_q;
   logic [1:0]        wrPtr_q, rdPtr_q;
   logic [1:0][1:0]   fifoCnt_q;

   assign opRs     = {req1_rs2, req1_rs1, req0_rs2, req0_rs1};
   assign opDep    = {req1_dep2, req1_dep1, req0_dep2, req0_dep1};
   assign opUse    = {req1_use2, req1_use1, req0_use2, req0_use1};
   assign reqValid = {req1_valid, req0_valid};
   assign rspReady = {rsp1_ready, rsp0_ready};
   // Tag 4'hF never indexes a real entry, so the padding bit is never used.
   assign vmaskPad = {1'b0, bp_vmask};

   // Classify each operand and decide which requesters can be served now.
   always_comb begin
      needG    = '0;
      needB    = '0;
      bpOk     = '0;
      gCnt     = '0;
      bCnt     = '0;
      eligible = '0;
      for (int i = 0; i < 4; i++) begin
         needB[i] = opUse[i] && (opDep[i] != 4'hF);
         needG[i] = opUse[i] && (opDep[i] == 4'hF) && (opRs[i] != 5'd0);
         bpOk[i]  = !needB[i] || vmaskPad[opDep[i]];
      end
      for (int n = 0; n < 2; n++) begin
         gCnt[n]     = 3'(needG[2*n]) + 3'(needG[2*n+1]);
         bCnt[n]     = 3'(needB[2*n]) + 3'(needB[2*n+1]);
         eligible[n] = reqValid[n] && (credit_q[n] != 2'd0) && bpOk[2*n] && bpOk[2*n+1];
      end
   end

   // Grant both when the two read-port pools cover both requests; otherwise
   // a starved requester wins first, then the round-robin pointer decides.
   always_comb begin
      grant  = '0;
      dualOk = ((gCnt[0] + gCnt[1]) <= 3'd2) && ((bCnt[0] + bCnt[1]) <= 3'd2);
      if (rst) begin
         grant = '0;
      end else if ((&eligible) && dualOk) begin
         grant = 2'b11;
      end else if (&eligible) begin
         if (starve_q[0] == LIMIT)      grant = 2'b01;
         else if (starve_q[1] == LIMIT) grant = 2'b10;
         else                           grant = rr_q ? 2'b10 : 2'b01;
      end else begin
         grant = eligible;
      end
   end

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   // Hand out read ports in slot order; the first operand needing a pool
   // takes port 0 and the second takes port 1. The chosen source and port
   // are remembered so the returning data can be steered one cycle later.
   always_comb begin
      logic gTaken;
      logic bTaken;
      gTaken     = 1'b0;
      bTaken     = 1'b0;
      grf_ren0   = 1'b0;
      grf_raddr0 = '0;
      grf_ren1   = 1'b0;
      grf_raddr1 = '0;
      bp_ren0    = 1'b0;
      bp_raddr0  = '0;
      bp_ren1    = 1'b0;
      bp_raddr1  = '0;
      opPort_d   = '0;
      for (int i = 0; i < 4; i++) begin
         opSrc_d[i] = SRC_ZERO;
         if (grant[i>>1] && needG[i]) begin
            opSrc_d[i] = SRC_GRF;
            if (!gTaken) begin
               grf_ren0   = 1'b1;
               grf_raddr0 = opRs[i];
               gTaken     = 1'b1;
            end else begin
               grf_ren1    = 1'b1;
               grf_raddr1  = opRs[i];
               opPort_d[i] = 1'b1;
            end
         end else if (grant[i>>1] && needB[i]) begin
            opSrc_d[i] = SRC_BP;
            if (!bTaken) begin
               bp_ren0   = 1'b1;
               bp_raddr0 = opDep[i];
               bTaken    = 1'b1;
            end else begin
               bp_ren1     = 1'b1;
               bp_raddr1   = opDep[i];
               opPort_d[i] = 1'b1;
            end
         end
      end
   end

   // Steer the read data of last cycle's grants into FIFO entries; operands
   // that were not read (unused or r0) are stored as zero.
   always_comb begin
      opData   = '0;
      pushData = '0;
      for (int i = 0; i < 4; i++) begin
         case (opSrc_q[i])
            SRC_GRF: opData[i] = opPort_q[i] ? grf_rdata1 : grf_rdata0;
            SRC_BP:  opData[i] = opPort_q[i] ? bp_rdata1 : bp_rdata0;
            default: opData[i] = 32'h0;
         endcase
      end
      for (int n = 0; n < 2; n++) begin
         pushData[n] = {opData[2*n+1], opData[2*n]};
      end
   end

   // Response side: the head entry is shown only while the FIFO holds data.
   always_comb begin
      head     = '0;
      rspValid = '0;
      pop      = '0;
      for (int n = 0; n < 2; n++) begin
         head[n]     = fifoMem_q[n][rdPtr_q[n]];
         rspValid[n] = !rst && (fifoCnt_q[n] != 2'd0);
         pop[n]      = rspValid[n] && rspReady[n];
      end
   end

   assign rsp0_valid = rspValid[0];
   assign rsp0_opl   = rspValid[0] ? head[0][31:0]  : 32'h0;
   assign rsp0_opr   = rspValid[0] ? head[0][63:32] : 32'h0;
   assign rsp1_valid = rspValid[1];
   assign rsp1_opl   = rspValid[1] ? head[1][31:0]  : 32'h0;
   assign rsp1_opr   = rspValid[1] ? head[1][63:32] : 32'h0;

   // Control state: read pipeline, credits, FIFO pointers, starvation
   // counters and round-robin pointer. Reset drops any read in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q    <= '0;
         opSrc_q   <= '{default: SRC_ZERO};
         opPort_q  <= '0;
         credit_q  <= {2'd2, 2'd2};
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         fifoCnt_q <= '0;
         starve_q  <= '0;
         rr_q      <= 1'b0;
      end else begin
         pend_q   <= grant;
         opSrc_q  <= opSrc_d;
         opPort_q <= opPort_d;
         for (int n = 0; n < 2; n++) begin
            case ({grant[n], pop[n]})
               2'b10:   credit_q[n] <= credit_q[n] - 2'd1;
               2'b01:   credit_q[n] <= credit_q[n] + 2'd1;
               default: credit_q[n] <= credit_q[n];
            endcase
            case ({pend_q[n], pop[n]})
               2'b10:   fifoCnt_q[n] <= fifoCnt_q[n] + 2'd1;
               2'b01:   fifoCnt_q[n] <= fifoCnt_q[n] - 2'd1;
               default: fifoCnt_q[n] <= fifoCnt_q[n];
            endcase
            if (pend_q[n]) wrPtr_q[n] <= ~wrPtr_q[n];
            if (pop[n])    rdPtr_q[n] <= ~rdPtr_q[n];
            if (eligible[n] && !grant[n])
               starve_q[n] <= (starve_q[n] == LIMIT) ? LIMIT : starve_q[n] + SW'(1);
            else
               starve_q[n] <= '0;
         end
         // Only a contested single grant moves the pointer, onto the loser.
         if ((&eligible) && (grant[0] != grant[1]))
            rr_q <= grant[0];
      end
   end

   // FIFO storage needs no reset; emptiness is tracked by the counters.
   always_ff @(posedge clk) begin
      for (int n = 0; n < 2; n++) begin
         if (pend_q[n] && !rst)
            fifoMem_q[n][wrPtr_q[n]] <= pushData[n];
      end
   end

endmodule
